// File: rtl/dif_butterfly_pipe_pkg.sv
// Shared types, constants and arithmetic helpers for the radix-2 DIF butterfly datapath.
// Q1.15 complex samples packed as {re, im}.
package dif_butterfly_pipe_pkg;

    localparam logic signed [15:0] Q15_ONE   = 16'sh7FFF;
    localparam logic signed [34:0] ROUND_Q15 = 35'sd1 <<< 14;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    function automatic logic signed [16:0] sx17(input logic [15:0] v);
        return {v[15], v};
    endfunction

    // Optional halving with round-half-up, done before saturation so it never clips early.
    function automatic logic signed [35:0] rnd_half(input logic signed [35:0] v, input logic scale);
        return scale ? ((v + 36'sd1) >>> 1) : v;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [35:0] v);
        if (v > 36'sd32767)
            return 16'sh7FFF;
        else if (v < -36'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/dif_butterfly_pipe_if.sv
// Handshake and data bundle between the stage memory reader, the butterfly and the writer.
// master drives the input side and out_ready; slave is the butterfly.
interface dif_butterfly_pipe_if #(parameter int TAG_W = 8);
    import dif_butterfly_pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    cplx_t            in_a;
    cplx_t            in_b;
    cplx_t            in_w;
    logic             in_inv;
    logic             in_scale;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    cplx_t            out1;
    cplx_t            out2;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_w, in_inv, in_scale, in_tag, out_ready,
        input  in_ready, out_valid, out1, out2, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_w, in_inv, in_scale, in_tag, out_ready,
        output in_ready, out_valid, out1, out2, out_tag
    );

endinterface

// File: rtl/dif_butterfly_pipe_cmul.sv
// Q1.15 complex multiply: products registered under en, then combinational sum and round-half-up.
// One register stage here; the caller registers the rounded result in its own output stage.
module cmul_q15
    import dif_butterfly_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic signed [16:0] d_re,
    input  logic signed [16:0] d_im,
    input  logic signed [16:0] w_re,
    input  logic signed [16:0] w_im,
    output logic signed [19:0] p_re,
    output logic signed [19:0] p_im
);

    logic signed [33:0] dre_x, dim_x, wre_x, wim_x;
    logic signed [33:0] rr, ii, ri, ir;
    logic signed [34:0] acc_re, acc_im, rnd_re, rnd_im;

    assign dre_x = {{17{d_re[16]}}, d_re};
    assign dim_x = {{17{d_im[16]}}, d_im};
    assign wre_x = {{17{w_re[16]}}, w_re};
    assign wim_x = {{17{w_im[16]}}, w_im};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr <= '0;
            ii <= '0;
            ri <= '0;
            ir <= '0;
        end else if (en) begin
            rr <= dre_x * wre_x;
            ii <= dim_x * wim_x;
            ri <= dre_x * wim_x;
            ir <= dim_x * wre_x;
        end
    end

    // 17x17 products fit 34 bits; one extra bit covers the sum, so nothing wraps.
    assign acc_re = {rr[33], rr} - {ii[33], ii};
    assign acc_im = {ri[33], ri} + {ir[33], ir};
    assign rnd_re = acc_re + ROUND_Q15;
    assign rnd_im = acc_im + ROUND_Q15;
    assign p_re   = rnd_re[34:15];
    assign p_im   = rnd_im[34:15];

endmodule

// File: rtl/dif_butterfly_pipe.sv
// Radix-2 DIF butterfly: out1 = a + b, out2 = (a - b) * w' (w' = conj(w) when inv), optional 1/2 scale.
// 3-cycle latency, 1/cycle; a single enable stalls the whole pipe while the output is held.
module dif_butterfly_pipe
    import dif_butterfly_pipe_pkg::*;
#(
    parameter int TAG_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    dif_butterfly_pipe_if.slave bus
);

    logic                    en;
    logic                    v1, v2, out_valid_q;
    logic signed [DATA_W:0]  s1_re, s1_im, d1_re, d1_im, w1_re, w1_im;
    logic signed [DATA_W:0]  s2_re, s2_im;
    logic                    scale1, scale2;
    logic [TAG_W-1:0]        tag1, tag2, out_tag_q;
    logic signed [19:0]      p_re, p_im;
    cplx_t                   out1_q, out2_q;
    logic signed [15:0]      o1_re, o1_im, o2_re, o2_im;

    // Bubbles are kept during a stall: every stage moves only when the output slot frees.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1     <= 1'b0;
            s1_re  <= '0;
            s1_im  <= '0;
            d1_re  <= '0;
            d1_im  <= '0;
            w1_re  <= '0;
            w1_im  <= '0;
            scale1 <= 1'b0;
            tag1   <= '0;
        end else if (en) begin
            v1     <= bus.in_valid;
            s1_re  <= sx17(bus.in_a.re) + sx17(bus.in_b.re);
            s1_im  <= sx17(bus.in_a.im) + sx17(bus.in_b.im);
            d1_re  <= sx17(bus.in_a.re) - sx17(bus.in_b.re);
            d1_im  <= sx17(bus.in_a.im) - sx17(bus.in_b.im);
            w1_re  <= sx17(bus.in_w.re);
            w1_im  <= bus.in_inv ? -sx17(bus.in_w.im) : sx17(bus.in_w.im);
            scale1 <= bus.in_scale;
            tag1   <= bus.in_tag;
        end
    end

    cmul_q15 u_cmul (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .d_re    (d1_re),
        .d_im    (d1_im),
        .w_re    (w1_re),
        .w_im    (w1_im),
        .p_re    (p_re),
        .p_im    (p_im)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v2     <= 1'b0;
            s2_re  <= '0;
            s2_im  <= '0;
            scale2 <= 1'b0;
            tag2   <= '0;
        end else if (en) begin
            v2     <= v1;
            s2_re  <= s1_re;
            s2_im  <= s1_im;
            scale2 <= scale1;
            tag2   <= tag1;
        end
    end

    always_comb begin
        o1_re = sat16(rnd_half({{(35-DATA_W){s2_re[DATA_W]}}, s2_re}, scale2));
        o1_im = sat16(rnd_half({{(35-DATA_W){s2_im[DATA_W]}}, s2_im}, scale2));
        o2_re = sat16(rnd_half({{16{p_re[19]}}, p_re}, scale2));
        o2_im = sat16(rnd_half({{16{p_im[19]}}, p_im}, scale2));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            out_valid_q <= v2;
            out1_q      <= {o1_re, o1_im};
            out2_q      <= {o2_re, o2_im};
            out_tag_q   <= tag2;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out1      = out1_q;
    assign bus.out2      = out2_q;
    assign bus.out_tag   = out_tag_q;

endmodule
